dot_product_engine: RTL and testbench
=====================================

DOT_PRODUCT_ENGINE -- requirements
Module: dot_product_engine

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, SRAM/WMEM address width.
REQ-002 SHALL have parameter DATA_W, default 16, signed data word width.
REQ-003 SHALL have parameter MAX_N, default 1024, maximum vector length (MAX_N <= 2^ADDR_W - 2).
REQ-004 SHALL have parameter ACC_W, default 2*DATA_W+11, signed accumulator width (>= 2*DATA_W + clog2(MAX_N)+1).
REQ-005 SHALL have parameter RESULT_ADDR, default 2^(ADDR_W-1), SRAM address receiving the result.
REQ-006 SHALL have parameter RELU, default 0, 1 = clamp negative results to zero.
REQ-007 SHALL have one clock and an asynchronous, active-low reset, with ports as listed below.
REQ-008 clk  input  1  clock; all state changes on rising edge.
REQ-009 reset_b  input  1  asynchronous active-low reset.
REQ-010 dut_run  input  1  start request, level-sensitive.
REQ-011 dut_busy  output  1  high while a computation is in progress.
REQ-012 dut_sram_read_address  output  ADDR_W  input SRAM read address.
REQ-013 sram_dut_read_data  input  DATA_W  SRAM read data, valid one cycle after its address.
REQ-014 dut_wmem_read_address  output  ADDR_W  weight memory read address.
REQ-015 wmem_dut_read_data  input  DATA_W  weight read data, valid one cycle after its address.
REQ-016 dut_sram_write_address  output  ADDR_W  SRAM write address.
REQ-017 dut_sram_write_data  output  DATA_W  SRAM write data.
REQ-018 dut_sram_write_enable  output  1  SRAM write strobe, one cycle per result.

Function
REQ-019 All outputs SHALL be registered.
REQ-020 SHALL implement states IDLE, HDR, HDR_WAIT, ACCUM, DRAIN, WRITE, DONE.
REQ-021 IDLE: dut_run=1 at an edge -> HDR; else stay.
REQ-022 HDR: drive dut_sram_read_address=0 (header word N); -> HDR_WAIT.
REQ-023 HDR_WAIT: latch N = sram_dut_read_data as unsigned, clamped to MAX_N; clear accumulator; N=0 -> WRITE, else -> ACCUM with index i=0.
REQ-024 ACCUM: each cycle drive dut_sram_read_address=1+i and dut_wmem_read_address=i, increment i; after i=N-1 issued -> DRAIN.
REQ-025 Data returned one cycle after each issue SHALL be multiplied signed x signed (2*DATA_W product), sign-extended and added to the ACC_W accumulator on that cycle's edge; valid flag pipelined alongside addresses.
REQ-026 DRAIN: accumulate final product; -> WRITE.
REQ-027 WRITE: dut_sram_write_enable=1 for exactly one cycle, dut_sram_write_address=RESULT_ADDR, dut_sram_write_data=result; -> DONE.
REQ-028 Result SHALL saturate accumulator to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; if RELU=1 negative results SHALL be written as 0.
REQ-029 dut_busy SHALL be 1 in HDR through WRITE, 0 in IDLE and DONE.
REQ-030 DONE: wait for dut_run=0, then -> IDLE; dut_run held high SHALL NOT retrigger.
REQ-031 dut_run changes while busy SHALL be ignored.
REQ-032 Latency: dut_run sampled at edge 0 -> write strobe high during cycle N+4 (N>=1), cycle 3 for N=0.
REQ-033 dut_sram_write_enable SHALL be 0 in every state other than WRITE.

Reset
REQ-034 reset_b=0 SHALL immediately force IDLE, dut_busy=0, dut_sram_write_enable=0, all addresses and write data 0, accumulator 0, i=0.
REQ-035 Reset asserted mid-operation SHALL abort with no write; the next run SHALL compute correctly from scratch.

Verification
REQ-036 N=3, inputs [2,-3,4], weights [5,6,-1], RELU=0 -> single write 16'hFFF4 (-12) to RESULT_ADDR in cycle 7 after run.
REQ-037 N=2, inputs [32767,32767], weights [32767,32767] -> write 16'h7FFF (positive saturation); negate weights -> 16'h8000.
REQ-038 RELU=1, stimulus of REQ-036 -> write 16'h0000; positive sum 10 -> 16'h000A.
REQ-039 N=0 -> no memory reads beyond address 0, write 16'h0000 in cycle 3, dut_busy high cycles 1-3.
REQ-040 reset_b pulsed low during ACCUM -> outputs reset at once, no write strobe; rerun with REQ-036 data -> 16'hFFF4.
REQ-041 dut_run held high through DONE -> exactly one write; dut_run low then high -> second computation starts.

Source files
------------

// File: rtl/dot_product_engine.sv
// Streams a header-length vector from SRAM and weights from WMEM, accumulates the
// signed dot product, then writes one saturated (optionally ReLU-clamped) result back.
module dot_product_engine #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned MAX_N       = 1024,
  parameter int unsigned ACC_W       = 2*DATA_W + 11,
  parameter int unsigned RESULT_ADDR = 2**(ADDR_W-1),
  parameter int unsigned RELU        = 0
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              dut_run,
  output logic              dut_busy,
  output logic [ADDR_W-1:0] dut_sram_read_address,
  input  logic [DATA_W-1:0] sram_dut_read_data,
  output logic [ADDR_W-1:0] dut_wmem_read_address,
  input  logic [DATA_W-1:0] wmem_dut_read_data,
  output logic [ADDR_W-1:0] dut_sram_write_address,
  output logic [DATA_W-1:0] dut_sram_write_data,
  output logic              dut_sram_write_enable
);

  localparam int unsigned PROD_W = 2*DATA_W;
  localparam int unsigned CMP_W  = DATA_W + ADDR_W;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] HDR      = 3'd1;
  localparam logic [2:0] HDR_WAIT = 3'd2;
  localparam logic [2:0] ACCUM    = 3'd3;
  localparam logic [2:0] DRAIN    = 3'd4;
  localparam logic [2:0] WRITE    = 3'd5;
  localparam logic [2:0] DONE     = 3'd6;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic [2:0]               state_q, state_d;
  logic [ADDR_W-1:0]        n_q, n_d, idx_q, idx_d;
  logic                     issue_q, issue_d, valid_q, valid_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     busy_q, busy_d;
  logic [ADDR_W-1:0]        rd_addr_q, rd_addr_d, w_addr_q, w_addr_d, wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]        wr_data_q, wr_data_d;
  logic                     we_q, we_d;

  logic signed [PROD_W-1:0] a_ext, b_ext, prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic [ADDR_W-1:0]        n_hdr;
  logic [DATA_W-1:0]        result;

  // Full-width signed product of the data returned this cycle
  always_comb begin
    a_ext    = PROD_W'($signed(sram_dut_read_data));
    b_ext    = PROD_W'($signed(wmem_dut_read_data));
    prod     = a_ext * b_ext;
    prod_ext = ACC_W'(prod);
    n_hdr    = (CMP_W'(sram_dut_read_data) > CMP_W'(MAX_N)) ? ADDR_W'(MAX_N)
                                                             : ADDR_W'(sram_dut_read_data);
  end

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    idx_d     = idx_q;
    issue_d   = 1'b0;
    valid_d   = issue_q;
    acc_d     = acc_q;
    rd_addr_d = '0;
    w_addr_d  = '0;
    wr_addr_d = '0;
    wr_data_d = '0;
    we_d      = 1'b0;
    result    = '0;

    if (valid_q) acc_d = acc_q + prod_ext;

    case (state_q)
      IDLE:     if (dut_run) state_d = HDR;
      HDR:      state_d = HDR_WAIT;
      HDR_WAIT: begin
        n_d   = n_hdr;
        acc_d = '0;
        idx_d = '0;
        if (n_hdr == '0) begin
          state_d = WRITE;
        end else begin
          state_d   = ACCUM;
          issue_d   = 1'b1;
          rd_addr_d = ADDR_W'(1);
          idx_d     = ADDR_W'(1);
        end
      end
      ACCUM: begin
        // idx_q is the next element to issue; all N issued means only the drain remains
        if (idx_q == n_q) begin
          state_d = DRAIN;
        end else begin
          issue_d   = 1'b1;
          rd_addr_d = idx_q + ADDR_W'(1);
          w_addr_d  = idx_q;
          idx_d     = idx_q + ADDR_W'(1);
        end
      end
      DRAIN:    state_d = WRITE;
      WRITE:    state_d = DONE;
      DONE:     if (!dut_run) state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    // Saturate to the data word range, then optionally clamp negatives
    if (acc_d > SAT_MAX)      result = {1'b0, {(DATA_W-1){1'b1}}};
    else if (acc_d < SAT_MIN) result = {1'b1, {(DATA_W-1){1'b0}}};
    else                      result = acc_d[DATA_W-1:0];
    if (RELU != 0 && acc_d[ACC_W-1]) result = '0;

    if (state_d == WRITE) begin
      we_d      = 1'b1;
      wr_addr_d = ADDR_W'(RESULT_ADDR);
      wr_data_d = result;
    end

    busy_d = (state_d != IDLE) && (state_d != DONE);
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q   <= IDLE;
      n_q       <= '0;
      idx_q     <= '0;
      issue_q   <= 1'b0;
      valid_q   <= 1'b0;
      acc_q     <= '0;
      busy_q    <= 1'b0;
      rd_addr_q <= '0;
      w_addr_q  <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      we_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      idx_q     <= idx_d;
      issue_q   <= issue_d;
      valid_q   <= valid_d;
      acc_q     <= acc_d;
      busy_q    <= busy_d;
      rd_addr_q <= rd_addr_d;
      w_addr_q  <= w_addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      we_q      <= we_d;
    end
  end

  assign dut_busy               = busy_q;
  assign dut_sram_read_address  = rd_addr_q;
  assign dut_wmem_read_address  = w_addr_q;
  assign dut_sram_write_address = wr_addr_q;
  assign dut_sram_write_data    = wr_data_q;
  assign dut_sram_write_enable  = we_q;

endmodule

// File: tb/tb_dot_product_engine.sv
// Directed bench for dot_product_engine: one plain instance and one with RELU=1
// sharing behavioural SRAM/WMEM models.
module tb_dot_product_engine;

  logic        clk = 1'b0;
  logic        reset_b = 1'b0;
  logic        run0 = 1'b0, run1 = 1'b0;
  logic        busy0, busy1, we0, we1;
  logic [11:0] raddr0, raddr1, waddr0, waddr1, wraddr0, wraddr1;
  logic [15:0] rdata0, rdata1, wdata0, wdata1, wrdata0, wrdata1;

  logic [15:0] sram_mem [0:4095];
  logic [15:0] wmem     [0:4095];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_cnt0 = 0, wr_cnt1 = 0, wr_cyc0 = 0, wr_cyc1 = 0;
  logic [11:0] wr_addr0 = '0, wr_addr1 = '0;
  logic [15:0] wr_data0 = '0, wr_data1 = '0;

  always #5 clk = ~clk;

  dot_product_engine #(.RELU(0)) dut0 (
    .clk(clk), .reset_b(reset_b), .dut_run(run0), .dut_busy(busy0),
    .dut_sram_read_address(raddr0), .sram_dut_read_data(rdata0),
    .dut_wmem_read_address(waddr0), .wmem_dut_read_data(wdata0),
    .dut_sram_write_address(wraddr0), .dut_sram_write_data(wrdata0),
    .dut_sram_write_enable(we0)
  );

  dot_product_engine #(.RELU(1)) dut1 (
    .clk(clk), .reset_b(reset_b), .dut_run(run1), .dut_busy(busy1),
    .dut_sram_read_address(raddr1), .sram_dut_read_data(rdata1),
    .dut_wmem_read_address(waddr1), .wmem_dut_read_data(wdata1),
    .dut_sram_write_address(wraddr1), .dut_sram_write_data(wrdata1),
    .dut_sram_write_enable(we1)
  );

  // Synchronous-read memories and write monitors
  always @(posedge clk) begin
    rdata0 <= sram_mem[raddr0];
    wdata0 <= wmem[waddr0];
    rdata1 <= sram_mem[raddr1];
    wdata1 <= wmem[waddr1];
    cyc    <= cyc + 1;
    if (we0) begin
      wr_cnt0 <= wr_cnt0 + 1; wr_addr0 <= wraddr0; wr_data0 <= wrdata0; wr_cyc0 <= cyc;
    end
    if (we1) begin
      wr_cnt1 <= wr_cnt1 + 1; wr_addr1 <= wraddr1; wr_data1 <= wrdata1; wr_cyc1 <= cyc;
    end
  end

  task automatic load(input int n, input int a0, input int a1, input int a2,
                      input int w0, input int w1, input int w2);
    sram_mem[0] = 16'(n);
    sram_mem[1] = 16'(a0); sram_mem[2] = 16'(a1); sram_mem[3] = 16'(a2);
    wmem[0] = 16'(w0); wmem[1] = 16'(w1); wmem[2] = 16'(w2);
  endtask

  task automatic set_run(input bit sel, input logic v);
    if (sel) run1 = v; else run0 = v;
  endtask

  // One run with a pulsed start plus a stray run pulse while busy
  task automatic run_check(input bit sel, input int n, input logic [15:0] exp, input string name);
    int c0, cnt_start, k, lat, cnt_now;
    logic [15:0] d;
    logic [11:0] a;
    @(negedge clk);
    cnt_start = sel ? wr_cnt1 : wr_cnt0;
    c0 = cyc;
    set_run(sel, 1'b1);
    @(negedge clk); set_run(sel, 1'b0);
    @(negedge clk); set_run(sel, 1'b1);
    @(negedge clk); set_run(sel, 1'b0);
    k = 0;
    while (((sel ? wr_cnt1 : wr_cnt0) == cnt_start) && k < 100) begin
      @(negedge clk); k++;
    end
    checks++;
    if (k >= 100) begin
      errors++; $display("FAIL %s timeout: no write strobe within 100 cycles", name);
    end else begin
      d   = sel ? wr_data1 : wr_data0;
      a   = sel ? wr_addr1 : wr_addr0;
      lat = (sel ? wr_cyc1 : wr_cyc0) - c0;
      checks++;
      if (d !== exp) begin errors++; $display("FAIL %s data: got %h expected %h", name, d, exp); end
      checks++;
      if (a !== 12'h800) begin errors++; $display("FAIL %s addr: got %h expected 800", name, a); end
      checks++;
      if (lat !== ((n == 0) ? 3 : n + 4)) begin
        errors++; $display("FAIL %s latency: got %0d expected %0d", name, lat, (n == 0) ? 3 : n + 4);
      end
    end
    repeat (6) @(negedge clk);
    cnt_now = sel ? wr_cnt1 : wr_cnt0;
    checks++;
    if (cnt_now - cnt_start !== 1) begin
      errors++; $display("FAIL %s write count: got %0d expected 1", name, cnt_now - cnt_start);
    end
    checks++;
    if ((sel ? busy1 : busy0) !== 1'b0) begin
      errors++; $display("FAIL %s busy after done: got %b expected 0", name, sel ? busy1 : busy0);
    end
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if ({busy0, we0, raddr0, waddr0, wraddr0, wrdata0} !== '0) begin
      errors++; $display("FAIL reset outputs: got %h expected 0", {busy0, we0, raddr0, waddr0, wraddr0, wrdata0});
    end
    @(negedge clk); reset_b = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy0, busy1, we0, we1} !== 4'b0) begin
      errors++; $display("FAIL idle after reset: got %b expected 0000", {busy0, busy1, we0, we1});
    end
  endtask

  task automatic test_basic;
    load(3, 2, -3, 4, 5, 6, -1);
    run_check(1'b0, 3, 16'hFFF4, "basic_n3");
    load(1, 2, 0, 0, 5, 0, 0);
    run_check(1'b0, 1, 16'h000A, "basic_n1");
  endtask

  task automatic test_saturation;
    load(2, 32767, 32767, 0, 32767, 32767, 0);
    run_check(1'b0, 2, 16'h7FFF, "sat_pos");
    load(2, 32767, 32767, 0, -32767, -32767, 0);
    run_check(1'b0, 2, 16'h8000, "sat_neg");
  endtask

  task automatic test_relu;
    load(3, 2, -3, 4, 5, 6, -1);
    run_check(1'b1, 3, 16'h0000, "relu_neg");
    load(1, 2, 0, 0, 5, 0, 0);
    run_check(1'b1, 1, 16'h000A, "relu_pos");
    load(2, 32767, 32767, 0, 32767, 32767, 0);
    run_check(1'b1, 2, 16'h7FFF, "relu_sat");
  endtask

  task automatic test_zero_length;
    logic [3:0] busy_seen;
    logic       addr_bad;
    load(0, 7, 7, 7, 7, 7, 7);
    @(negedge clk);
    run0 = 1'b1;
    addr_bad = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      run0 = 1'b0;
      busy_seen[c-1] = busy0;
      if (raddr0 !== 12'h0 || waddr0 !== 12'h0) addr_bad = 1'b1;
    end
    checks++;
    if (busy_seen !== 4'b0111) begin
      errors++; $display("FAIL zero_len busy cycles 4..1: got %b expected 0111", busy_seen);
    end
    checks++;
    if (addr_bad !== 1'b0) begin errors++; $display("FAIL zero_len read addr: nonzero address seen"); end
    repeat (4) @(negedge clk);
    run_check(1'b0, 0, 16'h0000, "zero_len");
  endtask

  task automatic test_reset_abort;
    int cnt_start;
    load(3, 2, -3, 4, 5, 6, -1);
    @(negedge clk);
    cnt_start = wr_cnt0;
    run0 = 1'b1;
    @(negedge clk); run0 = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy0 !== 1'b1) begin errors++; $display("FAIL abort pre busy: got %b expected 1", busy0); end
    reset_b = 1'b0;
    #1;
    checks++;
    if ({busy0, we0, raddr0, waddr0, wraddr0, wrdata0} !== '0) begin
      errors++; $display("FAIL abort outputs: got %h expected 0", {busy0, we0, raddr0, waddr0, wraddr0, wrdata0});
    end
    @(negedge clk); reset_b = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (wr_cnt0 !== cnt_start) begin
      errors++; $display("FAIL abort no write: got %0d writes expected 0", wr_cnt0 - cnt_start);
    end
    run_check(1'b0, 3, 16'hFFF4, "after_abort");
  endtask

  task automatic test_run_held;
    int cnt_start, k;
    load(3, 2, -3, 4, 5, 6, -1);
    @(negedge clk);
    cnt_start = wr_cnt0;
    run0 = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (wr_cnt0 - cnt_start !== 1) begin
      errors++; $display("FAIL held single write: got %0d expected 1", wr_cnt0 - cnt_start);
    end
    checks++;
    if (busy0 !== 1'b0) begin errors++; $display("FAIL held busy: got %b expected 0", busy0); end
    run0 = 1'b0;
    repeat (2) @(negedge clk);
    run0 = 1'b1;
    k = 0;
    while (wr_cnt0 - cnt_start < 2 && k < 100) begin @(negedge clk); k++; end
    run0 = 1'b0;
    checks++;
    if (wr_cnt0 - cnt_start !== 2) begin
      errors++; $display("FAIL held retrigger: got %0d writes expected 2", wr_cnt0 - cnt_start);
    end
    checks++;
    if (wr_data0 !== 16'hFFF4) begin
      errors++; $display("FAIL held second data: got %h expected fff4", wr_data0);
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin sram_mem[i] = '0; wmem[i] = '0; end
    test_reset;
    test_basic;
    test_saturation;
    test_relu;
    test_zero_length;
    test_reset_abort;
    test_run_held;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
